// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: 5..9 data bits, none/odd/even parity, 1 or 2 stop bits.
// Majority-of-three sampling around mid-bit; reports parity, framing and break per frame.
module uart_rx_cfg #(
    parameter int CLK_FREQ  = 25000000,
    parameter int BAUDRATE  = 921600,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 data_valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 break_det,
    output logic                 busy
);

    localparam int BIT_CLKS = CLK_FREQ / BAUDRATE;
    localparam int HALF_BIT = (BIT_CLKS - 1) / 2;
    localparam int CW       = $clog2(BIT_CLKS);
    localparam int IW       = $clog2(DATA_BITS);

    generate
        if (BIT_CLKS < 4 || DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2 ||
            STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_cfg
            $error("uart_rx_cfg: illegal parameter combination");
        end
    endgenerate

    localparam logic [CW-1:0] CNT_LAST  = CW'(BIT_CLKS - 1);
    localparam logic [CW-1:0] CNT_S0    = CW'(HALF_BIT - 1);
    localparam logic [CW-1:0] CNT_S1    = CW'(HALF_BIT);
    localparam logic [CW-1:0] CNT_DEC   = CW'(HALF_BIT + 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BITS - 1);
    localparam logic          STOP_LAST = (STOP_BITS == 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_WAIT_HIGH
    } state_e;

    state_e                 state_q, state_d;
    logic [1:0]             sync_q, sync_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic                   stop_idx_q, stop_idx_d;
    logic [1:0]             smp_q, smp_d;
    logic [DATA_BITS-1:0]   shreg_q, shreg_d;
    logic                   par_bit_q, par_bit_d;
    logic                   ferr_acc_q, ferr_acc_d;
    logic                   brk_acc_q, brk_acc_d;
    logic [DATA_BITS-1:0]   data_q, data_d;
    logic                   dv_q, dv_d;
    logic                   perr_q, perr_d;
    logic                   ferr_q, ferr_d;
    logic                   brk_q, brk_d;

    logic rx_s, maj, decide, bit_end, ferr_now, brk_now, par_bad;

    assign rx_s = sync_q[1];

    always_comb begin
        // NOTE: every target gets a default first so no path can infer a latch.
        state_d    = state_q;
        sync_d     = {sync_q[0], rx};
        cnt_d      = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
        idx_d      = idx_q;
        stop_idx_d = stop_idx_q;
        smp_d      = smp_q;
        shreg_d    = shreg_q;
        par_bit_d  = par_bit_q;
        ferr_acc_d = ferr_acc_q;
        brk_acc_d  = brk_acc_q;
        data_d     = data_q;
        dv_d       = 1'b0;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
        brk_d      = brk_q;

        if (cnt_q == CNT_S0) smp_d[0] = rx_s;
        if (cnt_q == CNT_S1) smp_d[1] = rx_s;
        maj     = (smp_q[0] & smp_q[1]) | (smp_q[0] & rx_s) | (smp_q[1] & rx_s);
        decide  = (cnt_q == CNT_DEC);
        bit_end = (cnt_q == CNT_LAST);

        // Odd parity wants the XOR over data+parity to be 1, even wants 0.
        par_bad  = (PARITY != 0) && ((^shreg_q ^ par_bit_q) != (PARITY == 1));
        ferr_now = ferr_acc_q | ~maj;
        brk_now  = (stop_idx_q == 1'b0)
                   ? ((shreg_q == '0) && ((PARITY == 0) || !par_bit_q) && !maj)
                   : brk_acc_q;

        case (state_q)
            S_IDLE: begin
                cnt_d      = '0;
                idx_d      = '0;
                stop_idx_d = 1'b0;
                ferr_acc_d = 1'b0;
                brk_acc_d  = 1'b0;
                if (!rx_s) state_d = S_START;
            end
            S_START: begin
                if (decide && maj) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (bit_end) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (decide) shreg_d[idx_q] = maj;
                if (bit_end) begin
                    if (idx_q == IDX_LAST) state_d = (PARITY != 0) ? S_PARITY : S_STOP;
                    else                   idx_d   = idx_q + 1'b1;
                end
            end
            S_PARITY: begin
                if (decide) par_bit_d = maj;
                if (bit_end) state_d = S_STOP;
            end
            S_STOP: begin
                if (decide) begin
                    ferr_acc_d = ferr_now;
                    brk_acc_d  = brk_now;
                    // Deliver at the last stop bit's decision so the next start edge is never missed.
                    if (stop_idx_q == STOP_LAST) begin
                        data_d  = shreg_q;
                        perr_d  = par_bad;
                        ferr_d  = ferr_now;
                        brk_d   = brk_now;
                        dv_d    = 1'b1;
                        cnt_d   = '0;
                        state_d = ferr_now ? S_WAIT_HIGH : S_IDLE;
                    end
                end else if (bit_end) begin
                    stop_idx_d = 1'b1;
                end
            end
            S_WAIT_HIGH: begin
                cnt_d = '0;
                if (rx_s) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: the shift register is reset too, so a frame cut by reset leaves no residue.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            sync_q     <= 2'b11;
            cnt_q      <= '0;
            idx_q      <= '0;
            stop_idx_q <= 1'b0;
            smp_q      <= 2'b11;
            shreg_q    <= '0;
            par_bit_q  <= 1'b0;
            ferr_acc_q <= 1'b0;
            brk_acc_q  <= 1'b0;
            data_q     <= '0;
            dv_q       <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            brk_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            sync_q     <= sync_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            stop_idx_q <= stop_idx_d;
            smp_q      <= smp_d;
            shreg_q    <= shreg_d;
            par_bit_q  <= par_bit_d;
            ferr_acc_q <= ferr_acc_d;
            brk_acc_q  <= brk_acc_d;
            data_q     <= data_d;
            dv_q       <= dv_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            brk_q      <= brk_d;
        end
    end

    assign data       = data_q;
    assign data_valid = dv_q;
    assign parity_err = perr_q;
    assign frame_err  = ferr_q;
    assign break_det  = brk_q;
    assign busy       = (state_q != S_IDLE);

endmodule
